// File: rtl/sram_write_strobe_if.sv
// CPU-side write request and SRAM strobe bundle for sram_write_strobe.
// master = CPU/bus decode side, slave = strobe generator.
interface sram_write_strobe_if;
  logic        we_req_b;
  logic        clear_stats;
  logic        ext_we_b;
  logic        data_oe;
  logic        busy;
  logic [15:0] write_count;
  logic        short_write;

  modport master (
    output we_req_b, clear_stats,
    input  ext_we_b, data_oe, busy, write_count, short_write
  );

  modport slave (
    input  we_req_b, clear_stats,
    output ext_we_b, data_oe, busy, write_count, short_write
  );
endinterface

// File: rtl/sram_write_strobe.sv
// SRAM write-enable strobe generator: setup / fixed-width pulse / hold around
// each CPU write, one strobe per request, with write statistics.
// Optional macro SRAM_WE_SYNC_EN: two-flop request synchroniser (D=2),
// otherwise a single register stage (D=1).
module sram_write_strobe #(
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 3,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              reset,
  sram_write_strobe_if.slave bus
);

  localparam int MAXC = (SETUP_CYCLES > PULSE_CYCLES) ?
                        ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                        ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] S_LD = CW'(SETUP_CYCLES);
  localparam logic [CW-1:0] P_LD = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] H_LD = CW'(HOLD_CYCLES);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, RELEASE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           req_s;
  logic           done, trunc;
  logic           ext_we_q, data_oe_q, short_q;
  logic [15:0]    count_q;

`ifdef SRAM_WE_SYNC_EN
  logic [1:0] sync_q;
  // Two-flop synchroniser; idles high so reset never looks like a request.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], bus.we_req_b};
  end
  assign req_s = sync_q[1];
`else
  logic sync_q;
  // Single capture stage for requests already in the clk domain.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 1'b1;
    else       sync_q <= bus.we_req_b;
  end
  assign req_s = sync_q;
`endif

  // State and phase counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: counter holds the cycles remaining in SETUP/PULSE/HOLD.
  // A PULSE that reaches its last cycle counts as complete even if the
  // request rises on that same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    trunc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!req_s) begin
          if (SETUP_CYCLES == 0) begin
            state_d = PULSE;
            cnt_d   = P_LD;
          end else begin
            state_d = SETUP;
            cnt_d   = S_LD;
          end
        end
      end
      SETUP: begin
        if (req_s) begin
          state_d = IDLE;
        end else if (cnt_q == ONE) begin
          state_d = PULSE;
          cnt_d   = P_LD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      PULSE: begin
        if (cnt_q == ONE) begin
          state_d = HOLD;
          cnt_d   = H_LD;
          done    = 1'b1;
        end else if (req_s) begin
          state_d = HOLD;
          cnt_d   = H_LD;
          trunc   = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = RELEASE;
        else             cnt_d   = cnt_q - ONE;
      end
      RELEASE: begin
        if (req_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // WE follows PULSE one cycle late so the first HOLD cycle still has data
  // driven while WE is low; data_oe tracks SETUP/PULSE/HOLD entry directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_we_q  <= 1'b1;
      data_oe_q <= 1'b0;
    end else begin
      ext_we_q  <= (state_q != PULSE);
      data_oe_q <= (state_d inside {SETUP, PULSE, HOLD});
    end
  end

  // Write statistics; clear wins over a same-cycle increment or set.
  always_ff @(posedge clk) begin
    if (reset || bus.clear_stats) begin
      count_q <= '0;
      short_q <= 1'b0;
    end else begin
      if (done)  count_q <= count_q + 16'd1;
      if (trunc) short_q <= 1'b1;
    end
  end

  assign bus.ext_we_b    = ext_we_q;
  assign bus.data_oe     = data_oe_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.write_count = count_q;
  assign bus.short_write = short_q;

endmodule
